// File: rtl/dma_icb_arb.sv
// Two-requester ICB arbiter: round-robin command grant with hold-while-stalled and an in-order ID FIFO
// that routes each response to its issuer. Define DMA_ARB_FIXED_PRIO_EN to give r0 fixed priority.
module dma_icb_arb #(
  parameter int OST_DEPTH = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_icb_cmd_valid,
  output logic            r0_icb_cmd_ready,
  input  logic            r0_icb_cmd_read,
  input  logic [AW-1:0]   r0_icb_cmd_addr,
  input  logic [DW-1:0]   r0_icb_cmd_wdata,
  input  logic [DW/8-1:0] r0_icb_cmd_wmask,
  output logic            r0_icb_rsp_valid,
  input  logic            r0_icb_rsp_ready,
  output logic [DW-1:0]   r0_icb_rsp_rdata,
  output logic            r0_icb_rsp_err,
  input  logic            r1_icb_cmd_valid,
  output logic            r1_icb_cmd_ready,
  input  logic            r1_icb_cmd_read,
  input  logic [AW-1:0]   r1_icb_cmd_addr,
  input  logic [DW-1:0]   r1_icb_cmd_wdata,
  input  logic [DW/8-1:0] r1_icb_cmd_wmask,
  output logic            r1_icb_rsp_valid,
  input  logic            r1_icb_rsp_ready,
  output logic [DW-1:0]   r1_icb_rsp_rdata,
  output logic            r1_icb_rsp_err,
  output logic            dma_icb_cmd_valid,
  input  logic            dma_icb_cmd_ready,
  output logic            dma_icb_cmd_read,
  output logic [AW-1:0]   dma_icb_cmd_addr,
  output logic [DW-1:0]   dma_icb_cmd_wdata,
  output logic [DW/8-1:0] dma_icb_cmd_wmask,
  input  logic            dma_icb_rsp_valid,
  output logic            dma_icb_rsp_ready,
  input  logic [DW-1:0]   dma_icb_rsp_rdata,
  input  logic            dma_icb_rsp_err
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OST_DEPTH);

  logic                 last_gnt;
  logic                 lock;
  logic                 lock_id;
  logic                 grant;
  logic [OST_DEPTH-1:0] id_fifo;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head;
  logic                 cmd_hs;
  logic                 rsp_hs;

  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);
  assign head       = id_fifo[rd_ptr];

  // A stalled command keeps its grant; otherwise alternate on contention.
  always_comb begin
    grant = 1'b0;
    if (lock) begin
      grant = lock_id;
    end else if (r0_icb_cmd_valid && r1_icb_cmd_valid) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_gnt;
`endif
    end else if (r1_icb_cmd_valid) begin
      grant = 1'b1;
    end
  end

  assign dma_icb_cmd_valid = (grant ? r1_icb_cmd_valid : r0_icb_cmd_valid) & ~fifo_full;
  assign dma_icb_cmd_read  = grant ? r1_icb_cmd_read  : r0_icb_cmd_read;
  assign dma_icb_cmd_addr  = grant ? r1_icb_cmd_addr  : r0_icb_cmd_addr;
  assign dma_icb_cmd_wdata = grant ? r1_icb_cmd_wdata : r0_icb_cmd_wdata;
  assign dma_icb_cmd_wmask = grant ? r1_icb_cmd_wmask : r0_icb_cmd_wmask;
  assign r0_icb_cmd_ready  = ~grant & dma_icb_cmd_ready & ~fifo_full;
  assign r1_icb_cmd_ready  =  grant & dma_icb_cmd_ready & ~fifo_full;
  assign cmd_hs            = dma_icb_cmd_valid & dma_icb_cmd_ready;

  // Responses return in issue order, so the FIFO head names the owner.
  assign dma_icb_rsp_ready = ~fifo_empty & (head ? r1_icb_rsp_ready : r0_icb_rsp_ready);
  assign r0_icb_rsp_valid  = dma_icb_rsp_valid & ~fifo_empty & ~head;
  assign r1_icb_rsp_valid  = dma_icb_rsp_valid & ~fifo_empty &  head;
  assign r0_icb_rsp_rdata  = dma_icb_rsp_rdata;
  assign r1_icb_rsp_rdata  = dma_icb_rsp_rdata;
  assign r0_icb_rsp_err    = dma_icb_rsp_err;
  assign r1_icb_rsp_err    = dma_icb_rsp_err;
  assign rsp_hs            = dma_icb_rsp_valid & dma_icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      lock     <= 1'b0;
      lock_id  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (dma_icb_cmd_valid && !dma_icb_cmd_ready) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end else if (cmd_hs) begin
        lock <= 1'b0;
      end
      if (cmd_hs) begin
        last_gnt <= grant;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (rsp_hs) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({cmd_hs, rsp_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ID storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      id_fifo[wr_ptr] <= grant;
    end
  end

endmodule

// File: tb/tb_dma_icb_arb.sv
// Directed self-checking bench for dma_icb_arb (OST_DEPTH=4), covering grant order, stall lock,
// full blocking, response routing, error pass-through and reset flush.
module tb_dma_icb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_icb_cmd_valid, r0_icb_cmd_ready, r0_icb_cmd_read;
  logic [31:0] r0_icb_cmd_addr, r0_icb_cmd_wdata;
  logic [3:0]  r0_icb_cmd_wmask;
  logic        r0_icb_rsp_valid, r0_icb_rsp_ready, r0_icb_rsp_err;
  logic [31:0] r0_icb_rsp_rdata;
  logic        r1_icb_cmd_valid, r1_icb_cmd_ready, r1_icb_cmd_read;
  logic [31:0] r1_icb_cmd_addr, r1_icb_cmd_wdata;
  logic [3:0]  r1_icb_cmd_wmask;
  logic        r1_icb_rsp_valid, r1_icb_rsp_ready, r1_icb_rsp_err;
  logic [31:0] r1_icb_rsp_rdata;
  logic        dma_icb_cmd_valid, dma_icb_cmd_ready, dma_icb_cmd_read;
  logic [31:0] dma_icb_cmd_addr, dma_icb_cmd_wdata;
  logic [3:0]  dma_icb_cmd_wmask;
  logic        dma_icb_rsp_valid, dma_icb_rsp_ready, dma_icb_rsp_err;
  logic [31:0] dma_icb_rsp_rdata;

  int checks = 0;
  int errors = 0;

  dma_icb_arb #(.OST_DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .r0_icb_cmd_valid(r0_icb_cmd_valid), .r0_icb_cmd_ready(r0_icb_cmd_ready),
    .r0_icb_cmd_read(r0_icb_cmd_read), .r0_icb_cmd_addr(r0_icb_cmd_addr),
    .r0_icb_cmd_wdata(r0_icb_cmd_wdata), .r0_icb_cmd_wmask(r0_icb_cmd_wmask),
    .r0_icb_rsp_valid(r0_icb_rsp_valid), .r0_icb_rsp_ready(r0_icb_rsp_ready),
    .r0_icb_rsp_rdata(r0_icb_rsp_rdata), .r0_icb_rsp_err(r0_icb_rsp_err),
    .r1_icb_cmd_valid(r1_icb_cmd_valid), .r1_icb_cmd_ready(r1_icb_cmd_ready),
    .r1_icb_cmd_read(r1_icb_cmd_read), .r1_icb_cmd_addr(r1_icb_cmd_addr),
    .r1_icb_cmd_wdata(r1_icb_cmd_wdata), .r1_icb_cmd_wmask(r1_icb_cmd_wmask),
    .r1_icb_rsp_valid(r1_icb_rsp_valid), .r1_icb_rsp_ready(r1_icb_rsp_ready),
    .r1_icb_rsp_rdata(r1_icb_rsp_rdata), .r1_icb_rsp_err(r1_icb_rsp_err),
    .dma_icb_cmd_valid(dma_icb_cmd_valid), .dma_icb_cmd_ready(dma_icb_cmd_ready),
    .dma_icb_cmd_read(dma_icb_cmd_read), .dma_icb_cmd_addr(dma_icb_cmd_addr),
    .dma_icb_cmd_wdata(dma_icb_cmd_wdata), .dma_icb_cmd_wmask(dma_icb_cmd_wmask),
    .dma_icb_rsp_valid(dma_icb_rsp_valid), .dma_icb_rsp_ready(dma_icb_rsp_ready),
    .dma_icb_rsp_rdata(dma_icb_rsp_rdata), .dma_icb_rsp_err(dma_icb_rsp_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; checks happen 1 ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    r0_icb_cmd_valid = 1'b0; r0_icb_cmd_read = 1'b1; r0_icb_cmd_addr = 32'h0000_0100;
    r0_icb_cmd_wdata = 32'h0000_00A0; r0_icb_cmd_wmask = 4'h3; r0_icb_rsp_ready = 1'b0;
    r1_icb_cmd_valid = 1'b0; r1_icb_cmd_read = 1'b0; r1_icb_cmd_addr = 32'h0000_0200;
    r1_icb_cmd_wdata = 32'h0000_00B0; r1_icb_cmd_wmask = 4'hC; r1_icb_rsp_ready = 1'b0;
    dma_icb_cmd_ready = 1'b0; dma_icb_rsp_valid = 1'b0;
    dma_icb_rsp_rdata = 32'h0; dma_icb_rsp_err = 1'b0;
  endtask

  // Presents n responses; bit i of ids is the owner expected for the i-th response.
  task automatic drain(input int n, input logic [3:0] ids);
    logic exp_id;
    for (int i = 0; i < n; i++) begin
      exp_id = ids[i];
      dma_icb_rsp_valid = 1'b1; dma_icb_rsp_rdata = 32'h5000 + i;
      r0_icb_rsp_ready = 1'b1; r1_icb_rsp_ready = 1'b1;
      settle();
      checks++;
      if ({r1_icb_rsp_valid, r0_icb_rsp_valid, dma_icb_rsp_ready} !== {exp_id, ~exp_id, 1'b1}) begin
        errors++;
        $display("[TB] FAIL drain_route[%0d]: got r1v/r0v/rdy=%b required %b", i,
                 {r1_icb_rsp_valid, r0_icb_rsp_valid, dma_icb_rsp_ready}, {exp_id, ~exp_id, 1'b1});
      end
      checks++;
      if (r0_icb_rsp_rdata !== 32'h5000 + i) begin
        errors++;
        $display("[TB] FAIL drain_rdata[%0d]: got %h required %h", i, r0_icb_rsp_rdata, 32'h5000 + i);
      end
      tick();
    end
    dma_icb_rsp_valid = 1'b0; r0_icb_rsp_ready = 1'b0; r1_icb_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    settle();
    checks++;
    if ({dma_icb_cmd_valid, dma_icb_rsp_ready, r0_icb_cmd_ready, r1_icb_cmd_ready,
         r0_icb_rsp_valid, r1_icb_rsp_valid} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b required 000000",
               {dma_icb_cmd_valid, dma_icb_rsp_ready, r0_icb_cmd_ready, r1_icb_cmd_ready,
                r0_icb_rsp_valid, r1_icb_rsp_valid});
    end
    checks++;
    if (dma_icb_cmd_addr !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL reset_mux_r0: got %h required %h", dma_icb_cmd_addr, 32'h0000_0100);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
`ifdef DMA_ARB_FIXED_PRIO_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b1010;
`endif
    r0_icb_cmd_valid = 1'b1; r1_icb_cmd_valid = 1'b1; dma_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({dma_icb_cmd_valid, r1_icb_cmd_ready, r0_icb_cmd_ready} !== {1'b1, exp_g[i], ~exp_g[i]}) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: got v/r1rdy/r0rdy=%b required %b", i,
                 {dma_icb_cmd_valid, r1_icb_cmd_ready, r0_icb_cmd_ready}, {1'b1, exp_g[i], ~exp_g[i]});
      end
      checks++;
      if ({dma_icb_cmd_addr, dma_icb_cmd_read, dma_icb_cmd_wmask} !==
          (exp_g[i] ? {32'h0000_0200, 1'b0, 4'hC} : {32'h0000_0100, 1'b1, 4'h3})) begin
        errors++;
        $display("[TB] FAIL rr_mux[%0d]: got addr %h read %b mask %h", i,
                 dma_icb_cmd_addr, dma_icb_cmd_read, dma_icb_cmd_wmask);
      end
      tick();
    end
    r0_icb_cmd_valid = 1'b0; r1_icb_cmd_valid = 1'b0; dma_icb_cmd_ready = 1'b0;
    drain(4, exp_g);
  endtask

  task automatic test_stall_lock();
    r1_icb_cmd_valid = 1'b1; r1_icb_cmd_addr = 32'h1000_0004; dma_icb_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) r0_icb_cmd_valid = 1'b1;
      if (i == 3) dma_icb_cmd_ready = 1'b1;
      settle();
      checks++;
      if ({dma_icb_cmd_valid, dma_icb_cmd_addr, r1_icb_cmd_ready, r0_icb_cmd_ready} !==
          {1'b1, 32'h1000_0004, (i == 3), 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got v %b addr %h r1rdy %b r0rdy %b", i,
                 dma_icb_cmd_valid, dma_icb_cmd_addr, r1_icb_cmd_ready, r0_icb_cmd_ready);
      end
      tick();
    end
    r1_icb_cmd_valid = 1'b0;
    settle();
    checks++;
    if ({dma_icb_cmd_addr, r0_icb_cmd_ready} !== {32'h0000_0100, 1'b1}) begin
      errors++;
      $display("[TB] FAIL stall_next_r0: got addr %h r0rdy %b required 00000100 1",
               dma_icb_cmd_addr, r0_icb_cmd_ready);
    end
    tick();
    r0_icb_cmd_valid = 1'b0; dma_icb_cmd_ready = 1'b0; r1_icb_cmd_addr = 32'h0000_0200;
    drain(2, 4'b0001);
  endtask

  task automatic test_fifo_full();
    r0_icb_cmd_valid = 1'b1; dma_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({dma_icb_cmd_valid, r0_icb_cmd_ready} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL full_fill[%0d]: got v/rdy %b required 11", i, {dma_icb_cmd_valid, r0_icb_cmd_ready});
      end
      tick();
    end
    settle();
    checks++;
    if ({dma_icb_cmd_valid, r0_icb_cmd_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL full_block: got v/rdy %b required 00", {dma_icb_cmd_valid, r0_icb_cmd_ready});
    end
    dma_icb_rsp_valid = 1'b1; dma_icb_rsp_rdata = 32'h77; r0_icb_rsp_ready = 1'b1;
    settle();
    checks++;
    if ({dma_icb_cmd_valid, r0_icb_cmd_ready, dma_icb_rsp_ready, r0_icb_rsp_valid} !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL full_same_cycle_pop: got v/rdy/rsprdy/r0rv %b required 0011",
               {dma_icb_cmd_valid, r0_icb_cmd_ready, dma_icb_rsp_ready, r0_icb_rsp_valid});
    end
    tick();
    dma_icb_rsp_valid = 1'b0; r0_icb_rsp_ready = 1'b0;
    settle();
    checks++;
    if ({dma_icb_cmd_valid, r0_icb_cmd_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL full_resume: got v/rdy %b required 11", {dma_icb_cmd_valid, r0_icb_cmd_ready});
    end
    tick();
    r0_icb_cmd_valid = 1'b0; dma_icb_cmd_ready = 1'b0;
    drain(4, 4'b0000);
  endtask

  task automatic issue(input logic id);
    r0_icb_cmd_valid = ~id; r1_icb_cmd_valid = id; dma_icb_cmd_ready = 1'b1;
    settle();
    checks++;
    if ({r1_icb_cmd_ready, r0_icb_cmd_ready} !== {id, ~id}) begin
      errors++;
      $display("[TB] FAIL issue_r%0d: got r1rdy/r0rdy %b required %b", id,
               {r1_icb_cmd_ready, r0_icb_cmd_ready}, {id, ~id});
    end
    tick();
    r0_icb_cmd_valid = 1'b0; r1_icb_cmd_valid = 1'b0; dma_icb_cmd_ready = 1'b0;
  endtask

  task automatic test_routing();
    issue(1'b0); issue(1'b1); issue(1'b0);
    dma_icb_rsp_valid = 1'b1; dma_icb_rsp_rdata = 32'hA; r0_icb_rsp_ready = 1'b1; r1_icb_rsp_ready = 1'b0;
    settle();
    checks++;
    if ({r0_icb_rsp_valid, r1_icb_rsp_valid, dma_icb_rsp_ready, r0_icb_rsp_rdata} !== {3'b101, 32'hA}) begin
      errors++;
      $display("[TB] FAIL route_first: got r0v %b r1v %b rdy %b rdata %h required 1 0 1 0000000a",
               r0_icb_rsp_valid, r1_icb_rsp_valid, dma_icb_rsp_ready, r0_icb_rsp_rdata);
    end
    tick();
    dma_icb_rsp_rdata = 32'hB;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({r0_icb_rsp_valid, r1_icb_rsp_valid, dma_icb_rsp_ready} !== 3'b010) begin
        errors++;
        $display("[TB] FAIL route_r1_stall[%0d]: got r0v/r1v/rdy %b required 010", i,
                 {r0_icb_rsp_valid, r1_icb_rsp_valid, dma_icb_rsp_ready});
      end
      tick();
    end
    r1_icb_rsp_ready = 1'b1;
    settle();
    checks++;
    if ({r1_icb_rsp_valid, dma_icb_rsp_ready, r1_icb_rsp_rdata} !== {2'b11, 32'hB}) begin
      errors++;
      $display("[TB] FAIL route_second: got r1v %b rdy %b rdata %h required 1 1 0000000b",
               r1_icb_rsp_valid, dma_icb_rsp_ready, r1_icb_rsp_rdata);
    end
    tick();
    dma_icb_rsp_rdata = 32'hC;
    settle();
    checks++;
    if ({r0_icb_rsp_valid, r1_icb_rsp_valid, r0_icb_rsp_rdata} !== {2'b10, 32'hC}) begin
      errors++;
      $display("[TB] FAIL route_third: got r0v %b r1v %b rdata %h required 1 0 0000000c",
               r0_icb_rsp_valid, r1_icb_rsp_valid, r0_icb_rsp_rdata);
    end
    tick();
    settle();
    checks++;
    if ({dma_icb_rsp_ready, r0_icb_rsp_valid, r1_icb_rsp_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL route_empty_stray: got rdy/r0v/r1v %b required 000",
               {dma_icb_rsp_ready, r0_icb_rsp_valid, r1_icb_rsp_valid});
    end
    dma_icb_rsp_valid = 1'b0; r0_icb_rsp_ready = 1'b0; r1_icb_rsp_ready = 1'b0;
  endtask

  task automatic test_error();
    issue(1'b1);
    dma_icb_rsp_valid = 1'b1; dma_icb_rsp_err = 1'b1; dma_icb_rsp_rdata = 32'hE;
    r0_icb_rsp_ready = 1'b1; r1_icb_rsp_ready = 1'b1;
    settle();
    checks++;
    if ({r1_icb_rsp_valid, r1_icb_rsp_err, r0_icb_rsp_valid, dma_icb_rsp_ready} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL err_route: got r1v/r1err/r0v/rdy %b required 1101",
               {r1_icb_rsp_valid, r1_icb_rsp_err, r0_icb_rsp_valid, dma_icb_rsp_ready});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_flush();
    logic [3:0] exp_g;
`ifdef DMA_ARB_FIXED_PRIO_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b0010;
`endif
    issue(1'b0); issue(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dma_icb_rsp_valid = 1'b1; r0_icb_rsp_ready = 1'b1; r1_icb_rsp_ready = 1'b1;
    settle();
    checks++;
    if ({dma_icb_rsp_ready, r0_icb_rsp_valid, r1_icb_rsp_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL flush_dropped: got rdy/r0v/r1v %b required 000",
               {dma_icb_rsp_ready, r0_icb_rsp_valid, r1_icb_rsp_valid});
    end
    tick();
    dma_icb_rsp_valid = 1'b0; r0_icb_rsp_ready = 1'b0; r1_icb_rsp_ready = 1'b0;
    r0_icb_cmd_valid = 1'b1; r1_icb_cmd_valid = 1'b1; dma_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({r1_icb_cmd_ready, r0_icb_cmd_ready} !== {exp_g[i], ~exp_g[i]}) begin
        errors++;
        $display("[TB] FAIL flush_grant[%0d]: got r1rdy/r0rdy %b required %b", i,
                 {r1_icb_cmd_ready, r0_icb_cmd_ready}, {exp_g[i], ~exp_g[i]});
      end
      tick();
    end
    r0_icb_cmd_valid = 1'b0; r1_icb_cmd_valid = 1'b0; dma_icb_cmd_ready = 1'b0;
    drain(2, exp_g);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_stall_lock();
    test_fifo_full();
    test_routing();
    test_error();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
